// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_responder
// Brief    : Block-RAM backed stand-in for an SDR SDRAM slice. Decodes the
//            command bus, tracks per-bank open rows, follows the power-up
//            init sequence, returns read data after CAS latency and raises
//            sticky flags on protocol violations.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_responder #(
   parameter int MEM_AW   = 14,
   parameter int COL_W    = 10,   // columns come from A[COL_W-1:0]; COL_W <= 10
   parameter int TRCD     = 2,
   parameter int TRFC     = 7,
   parameter int TREF_MAX = 1600
) (
   input  logic        clk,
   input  logic        init,
   input  logic        sdram_ncs,
   input  logic        sdram_nras,
   input  logic        sdram_ncas,
   input  logic        sdram_nwe,
   input  logic        sdram_cke,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic        sdram_dqml,
   input  logic        sdram_dqmh,
   input  logic [15:0] sdram_dq_i,
   output logic [15:0] sdram_dq_o,
   output logic        sdram_dq_oe,
   output logic [12:0] mode_reg,
   output logic        init_done,
   output logic [7:0]  err
);

   localparam logic [2:0] c_CMD_ACT = 3'b011;
   localparam logic [2:0] c_CMD_RD  = 3'b101;
   localparam logic [2:0] c_CMD_WR  = 3'b100;
   localparam logic [2:0] c_CMD_PRE = 3'b010;
   localparam logic [2:0] c_CMD_REF = 3'b001;
   localparam logic [2:0] c_CMD_LMR = 3'b000;

   localparam int c_TRCD_W = $clog2(TRCD + 1);
   localparam int c_TRFC_W = $clog2(TRFC + 1);
   localparam int c_TREF_W = $clog2(TREF_MAX + 1);
   localparam int c_FULL_W = 2 + 13 + COL_W;
   localparam logic [c_TRCD_W-1:0] c_TRCD_SAT  = c_TRCD_W'(TRCD);
   localparam logic [c_TRFC_W-1:0] c_TRFC_LOAD = c_TRFC_W'(TRFC);
   localparam logic [c_TREF_W-1:0] c_TREF_SAT  = c_TREF_W'(TREF_MAX);

   typedef enum logic [2:0] {
      ST_WAIT_PRE  = 3'd0,
      ST_WAIT_REF1 = 3'd1,
      ST_WAIT_REF2 = 3'd2,
      ST_WAIT_MODE = 3'd3,
      ST_READY     = 3'd4
   } init_state_t;

   init_state_t          r_state;
   init_state_t          w_state_nxt;
   logic                 r_init_done;
   logic [3:0]           r_bank_open;
   logic [12:0]          r_bank_row [4];
   logic [c_TRCD_W-1:0]  r_trcd_cnt [4];
   logic [c_TRFC_W-1:0]  r_trfc_cnt;
   logic [c_TREF_W-1:0]  r_tref_cnt;
   logic [12:0]          r_mode;
   logic [7:0]           r_err;
   logic [7:0]           w_err_set;
   logic [15:0]          r_mem [1 << MEM_AW];
   logic [15:0]          r_rd_word;
   logic [15:0]          r_rd_d1;
   logic                 r_rd_v0;
   logic                 r_rd_v1;
   logic [15:0]          r_dq_o;
   logic                 r_dq_oe;

   logic                 w_sel;
   logic [2:0]           w_cmd;
   logic                 w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_cmd_any;
   logic                 w_a10;
   logic                 w_bank_open;
   logic                 w_any_open;
   logic                 w_access;
   logic [2:0]           w_new_cl;
   logic                 w_cl3;
   logic [c_FULL_W-1:0]  w_full_idx;
   logic [MEM_AW-1:0]    w_idx;

   assign w_sel       = !sdram_ncs && sdram_cke;
   assign w_cmd       = {sdram_nras, sdram_ncas, sdram_nwe};
   assign w_act       = w_sel && (w_cmd == c_CMD_ACT);
   assign w_rd        = w_sel && (w_cmd == c_CMD_RD);
   assign w_wr        = w_sel && (w_cmd == c_CMD_WR);
   assign w_pre       = w_sel && (w_cmd == c_CMD_PRE);
   assign w_ref       = w_sel && (w_cmd == c_CMD_REF);
   assign w_lmr       = w_sel && (w_cmd == c_CMD_LMR);
   assign w_cmd_any   = w_act || w_rd || w_wr || w_pre || w_ref || w_lmr;
   assign w_a10       = sdram_a[10];
   assign w_bank_open = r_bank_open[sdram_ba];
   assign w_any_open  = |r_bank_open;
   // A column access only touches the array when init has completed and the bank is open
   assign w_access    = (w_rd || w_wr) && r_init_done && w_bank_open;
   assign w_new_cl    = sdram_a[6:4];
   assign w_cl3       = (r_mode[6:4] == 3'd3);
   // Word index is {bank,row,col} with the upper bits dropped to fit the RAM
   assign w_full_idx  = {sdram_ba, r_bank_row[sdram_ba], sdram_a[COL_W-1:0]};
   assign w_idx       = MEM_AW'(w_full_idx);

   assign sdram_dq_o  = r_dq_o;
   assign sdram_dq_oe = r_dq_oe;
   assign mode_reg    = r_mode;
   assign init_done   = r_init_done;
   assign err         = r_err;

   // Init FSM state register; init_done stays set once READY has been reached
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_state     <= ST_WAIT_PRE;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_done <= r_init_done || (w_state_nxt == ST_READY);
      end
   end

   // Init FSM next state: PRECHARGE-all, two refreshes, mode load
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_WAIT_PRE:  if (w_pre && w_a10) w_state_nxt = ST_WAIT_REF1;
         ST_WAIT_REF1: if (w_ref)          w_state_nxt = ST_WAIT_REF2;
         ST_WAIT_REF2: if (w_ref)          w_state_nxt = ST_WAIT_MODE;
         ST_WAIT_MODE: if (w_lmr)          w_state_nxt = ST_READY;
         ST_READY:     if (w_pre && w_a10) w_state_nxt = ST_WAIT_REF1;
         default:                          w_state_nxt = ST_WAIT_PRE;
      endcase
   end

   // Protocol violations detected on the current command edge
   always_comb begin
      w_err_set    = 8'h00;
      w_err_set[0] = w_act && r_init_done && w_bank_open;
      w_err_set[1] = (w_rd || w_wr) && r_init_done && !w_bank_open;
      w_err_set[2] = (w_act || w_rd || w_wr) && !r_init_done;
      w_err_set[3] = w_lmr && (!(w_new_cl == 3'd2 || w_new_cl == 3'd3) ||
                               (sdram_a[2:0] != 3'd0) || w_any_open);
      w_err_set[4] = w_access && (r_trcd_cnt[sdram_ba] < c_TRCD_SAT);
      w_err_set[5] = w_ref && w_any_open;
      w_err_set[6] = w_cmd_any && (r_trfc_cnt != '0);
      w_err_set[7] = r_init_done && (r_tref_cnt == c_TREF_SAT) && !w_ref;
   end

   // Sticky error flags, mode register and refresh timing counters
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_err      <= 8'h00;
         r_mode     <= 13'h0000;
         r_trfc_cnt <= '0;
         r_tref_cnt <= '0;
      end else begin
         r_err <= r_err | w_err_set;
         if (w_lmr) r_mode <= sdram_a;
         if (w_ref)                   r_trfc_cnt <= c_TRFC_LOAD;
         else if (r_trfc_cnt != '0)   r_trfc_cnt <= r_trfc_cnt - c_TRFC_W'(1);
         if (w_ref)                   r_tref_cnt <= '0;
         else if (r_init_done && (r_tref_cnt != c_TREF_SAT))
                                      r_tref_cnt <= r_tref_cnt + c_TREF_W'(1);
      end
   end

   // Per-bank open row tracking and ACTIVE-to-access cycle counters
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_bank_open <= 4'h0;
         for (int b = 0; b < 4; b++) begin
            r_bank_row[b] <= 13'h0000;
            r_trcd_cnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (r_trcd_cnt[b] != c_TRCD_SAT) r_trcd_cnt[b] <= r_trcd_cnt[b] + c_TRCD_W'(1);
         end
         if (w_act && r_init_done) begin
            r_bank_open[sdram_ba] <= 1'b1;
            r_bank_row[sdram_ba]  <= sdram_a;
            r_trcd_cnt[sdram_ba]  <= c_TRCD_W'(1);
         end
         if (w_pre) begin
            if (w_a10) r_bank_open <= 4'h0;
            else       r_bank_open[sdram_ba] <= 1'b0;
         end
         if (w_access && w_a10) r_bank_open[sdram_ba] <= 1'b0;
      end
   end

   // Storage array with byte-masked writes; read word captured on the command edge
   always_ff @(posedge clk) begin
      if (w_access && w_wr) begin
         if (!sdram_dqml) r_mem[w_idx][7:0]  <= sdram_dq_i[7:0];
         if (!sdram_dqmh) r_mem[w_idx][15:8] <= sdram_dq_i[15:8];
      end
      r_rd_word <= r_mem[w_idx];
   end

   // CAS-latency pipeline: CL=2 drives from stage 0, CL=3 from stage 1
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         r_rd_v0 <= 1'b0;
         r_rd_v1 <= 1'b0;
         r_rd_d1 <= 16'h0000;
         r_dq_o  <= 16'h0000;
         r_dq_oe <= 1'b0;
      end else begin
         r_rd_v0 <= w_access && w_rd;
         r_rd_v1 <= r_rd_v0;
         r_rd_d1 <= r_rd_word;
         if (w_cl3 ? r_rd_v1 : r_rd_v0) begin
            r_dq_oe <= 1'b1;
            r_dq_o  <= w_cl3 ? r_rd_d1 : r_rd_word;
         end else begin
            r_dq_oe <= 1'b0;
            r_dq_o  <= 16'h0000;
         end
      end
   end

endmodule
`default_nettype wire
